// File: rtl/selector_pkg.sv
// Shared types and widths for the selector_arb sequencer and the selector4
// nibble-gather datapath it drives.
package selector_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int SEL_W   = 12;  // four 3-bit nibble indices
  localparam int SELAB_W = 4;   // one A/B lane select per output nibble
  localparam int NIB_W   = 16;  // four gathered nibbles

  // Extract nibble idx (0..7) from a 32-bit data word.
  function automatic logic [3:0] pick_nibble(input logic [31:0] data, input logic [2:0] idx);
    return data[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/selector_arb_if.sv
// Requester-side bus of selector_arb: per-requester request and gather
// configuration in, grant / completion / result out.
interface selector_arb_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  import selector_pkg::*;

  logic [NREQ-1:0]         req;
  logic [NREQ*SEL_W-1:0]   req_sel_a;
  logic [NREQ*SEL_W-1:0]   req_sel_b;
  logic [NREQ*SELAB_W-1:0] req_sel_ab;
  logic [NREQ-1:0]         gnt;
  logic [NIB_W-1:0]        result;
  logic                    done;
  logic [IDW-1:0]          done_id;
  logic                    busy;

  // Client side
  modport master (
    output req, req_sel_a, req_sel_b, req_sel_ab,
    input  gnt, result, done, done_id, busy
  );

  // Arbiter side
  modport slave (
    input  req, req_sel_a, req_sel_b, req_sel_ab,
    output gnt, result, done, done_id, busy
  );

endinterface

// File: rtl/selector4.sv
// selector4: registered nibble gather. Output nibble k takes nibble
// sel_x[3k+:3] of data_b when sel_ab[k]=1, else of data_a. One register
// stage, synchronous active-low reset.
module selector4
  import selector_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         data_a,
  input  logic [31:0]         data_b,
  input  logic [SEL_W-1:0]    sel_a,
  input  logic [SEL_W-1:0]    sel_b,
  input  logic [SELAB_W-1:0]  sel_ab,
  output logic [NIB_W-1:0]    nibbles
);

  logic [NIB_W-1:0] gather_next;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign gather_next[gi*4 +: 4] = sel_ab[gi] ? pick_nibble(data_b, sel_b[gi*3 +: 3])
                                               : pick_nibble(data_a, sel_a[gi*3 +: 3]);
  end

  // Register the gathered word
  always_ff @(posedge clk) begin
    if (!rst_n) nibbles <= '0;
    else        nibbles <= gather_next;
  end

endmodule

// File: rtl/selector_arb_rr_pick.sv
// rr_pick: combinational rotating-priority picker. Searches req starting at
// ptr and wrapping modulo NREQ; reports one-hot grant, binary id and whether
// anything was found. With SELECTOR_ARB_FIXED_PRIO_EN defined the pointer is
// ignored (tied to 0), giving lowest-index-wins priority.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  id,
  output logic            valid
);

  logic [IDW-1:0] base;

`ifdef SELECTOR_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign base       = '0;
`else
  assign base = ptr;
`endif

  // First asserted request at or after base, in wrap-around order
  always_comb begin
    logic [IDW-1:0] idx;
    gnt   = '0;
    id    = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(base) + i) % NREQ);
      if (!valid && req[idx]) begin
        valid    = 1'b1;
        id       = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/selector_arb.sv
// selector_arb: shares one selector4 gather datapath among NREQ requesters.
// IDLE picks a winner and registers its configuration onto sel_*, ISSUE lets
// selector4 sample it, WAIT captures nibbles with a one-cycle done pulse,
// RESP clears grant and returns to IDLE (one gather per 4 cycles).
// Build option: SELECTOR_ARB_FIXED_PRIO_EN selects fixed lowest-index
// priority instead of round-robin (no rotating pointer in that build).
module selector_arb
  import selector_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               reset,
  selector_arb_if.slave      bus,
  output logic [SEL_W-1:0]   sel_a,
  output logic [SEL_W-1:0]   sel_b,
  output logic [SELAB_W-1:0] sel_ab,
  input  logic [NIB_W-1:0]   nibbles
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_WAIT  = WAIT;
  localparam logic [1:0] ST_RESP  = RESP;

  logic [1:0]         state_reg;
  logic [IDW-1:0]     id_reg;
  logic [NREQ-1:0]    gnt_reg;
  logic [SEL_W-1:0]   sel_a_reg;
  logic [SEL_W-1:0]   sel_b_reg;
  logic [SELAB_W-1:0] sel_ab_reg;
  logic [NIB_W-1:0]   result_reg;
  logic               done_reg;
  logic [IDW-1:0]     done_id_reg;

  logic [NREQ-1:0]    pick_gnt;
  logic [IDW-1:0]     pick_id;
  logic               pick_valid;

  // Per-requester configuration slices
  logic [SEL_W-1:0]   cfg_a  [NREQ];
  logic [SEL_W-1:0]   cfg_b  [NREQ];
  logic [SELAB_W-1:0] cfg_ab [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cfg
    assign cfg_a[gi]  = bus.req_sel_a[gi*SEL_W +: SEL_W];
    assign cfg_b[gi]  = bus.req_sel_b[gi*SEL_W +: SEL_W];
    assign cfg_ab[gi] = bus.req_sel_ab[gi*SELAB_W +: SELAB_W];
  end

`ifdef SELECTOR_ARB_FIXED_PRIO_EN
  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req   (bus.req),
    .ptr   ('0),
    .gnt   (pick_gnt),
    .id    (pick_id),
    .valid (pick_valid)
  );
`else
  logic [IDW-1:0] rr_ptr_reg;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req   (bus.req),
    .ptr   (rr_ptr_reg),
    .gnt   (pick_gnt),
    .id    (pick_id),
    .valid (pick_valid)
  );

  // Rotate priority to one past each winner
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg <= '0;
    end else if (state_reg == ST_IDLE && pick_valid) begin
      rr_ptr_reg <= (pick_id == IDW'(NREQ - 1)) ? '0 : pick_id + 1'b1;
    end
  end
`endif

  // Grant / issue / capture / release sequencer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      id_reg      <= '0;
      gnt_reg     <= '0;
      sel_a_reg   <= '0;
      sel_b_reg   <= '0;
      sel_ab_reg  <= '0;
      result_reg  <= '0;
      done_reg    <= 1'b0;
      done_id_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pick_valid) begin
            id_reg     <= pick_id;
            gnt_reg    <= pick_gnt;
            sel_a_reg  <= cfg_a[pick_id];
            sel_b_reg  <= cfg_b[pick_id];
            sel_ab_reg <= cfg_ab[pick_id];
            state_reg  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          result_reg  <= nibbles;
          done_reg    <= 1'b1;
          done_id_reg <= id_reg;
          state_reg   <= ST_RESP;
        end
        default: begin
          done_reg  <= 1'b0;
          gnt_reg   <= '0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign sel_a       = sel_a_reg;
  assign sel_b       = sel_b_reg;
  assign sel_ab      = sel_ab_reg;
  assign bus.gnt     = gnt_reg;
  assign bus.result  = result_reg;
  assign bus.done    = done_reg;
  assign bus.done_id = done_id_reg;
  assign bus.busy    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_selector_arb.sv
// Bench for selector_arb driving a real selector4 with fixed data words.
// Table of single-request gathers, then reset-in-WAIT, round-robin order
// and pointer wrap sequences. Honours SELECTOR_ARB_FIXED_PRIO_EN.
module tb_selector_arb;
  import selector_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef struct {
    logic [3:0]  req;
    logic [1:0]  id;
    logic [11:0] sel_a;
    logic [11:0] sel_b;
    logic [3:0]  sel_ab;
    logic [15:0] exp_result;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] sel_a, sel_b;
  logic [3:0]  sel_ab;
  logic [15:0] nibbles;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  vec_t        vecs [5];

  selector_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  selector_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .sel_a   (sel_a),
    .sel_b   (sel_b),
    .sel_ab  (sel_ab),
    .nibbles (nibbles)
  );

  selector4 u_sel4 (
    .clk     (clk),
    .rst_n   (!reset),
    .data_a  (32'h76543210),
    .data_b  (32'hFEDCBA98),
    .sel_a   (sel_a),
    .sel_b   (sel_b),
    .sel_ab  (sel_ab),
    .nibbles (nibbles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      if (bus.done === 1'b1) seen = 1'b1;
    end
  endtask

  // One complete single-request transaction; request drops during ISSUE.
  task automatic run_vec(input vec_t v, input string tag);
    int id;
    id = int'(v.id);
    bus.req_sel_a[id*12 +: 12] = v.sel_a;
    bus.req_sel_b[id*12 +: 12] = v.sel_b;
    bus.req_sel_ab[id*4 +: 4]  = v.sel_ab;
    bus.req = v.req;
    tick();  // edge 0
    chk({tag, "_gnt"},    32'(bus.gnt), 32'(1) << id);
    chk({tag, "_busy"},   32'(bus.busy), 32'd1);
    chk({tag, "_sel_a"},  32'(sel_a), 32'(v.sel_a));
    chk({tag, "_sel_b"},  32'(sel_b), 32'(v.sel_b));
    chk({tag, "_sel_ab"}, 32'(sel_ab), 32'(v.sel_ab));
    bus.req = '0;
    tick();  // edge 1
    chk({tag, "_done_early"}, 32'(bus.done), 32'd0);
    tick();  // edge 2
    chk({tag, "_done"},    32'(bus.done), 32'd1);
    chk({tag, "_done_id"}, 32'(bus.done_id), 32'(id));
    chk({tag, "_result"},  32'(bus.result), 32'(v.exp_result));
    $display("txn %s id=%0d result=%h expect=%h", tag, bus.done_id, bus.result, v.exp_result);
    tick();  // edge 3
    chk({tag, "_done_clr"}, 32'(bus.done), 32'd0);
    chk({tag, "_idle"},     32'(bus.busy), 32'd0);
    chk({tag, "_gnt_clr"},  32'(bus.gnt), 32'd0);
  endtask

  // All four requests held; each drops after its own done. order packs the
  // expected completion ids, first in the low bits.
  task automatic rr_run(input logic [7:0] order, input string tag);
    int         last;
    bit         seen;
    logic [1:0] idb;
    last = 0;
    bus.req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_done(8, seen);
      idb = 2'(order >> (2 * k));
      chk($sformatf("%s_seen%0d", tag, k), 32'(seen), 32'd1);
      chk($sformatf("%s_id%0d", tag, k), 32'(bus.done_id), 32'(idb));
      if (k > 0) chk($sformatf("%s_gap%0d", tag, k), 32'(cyc - last), 32'd4);
      $display("txn %s k=%0d id=%0d expect=%0d cyc=%0d", tag, k, bus.done_id, idb, cyc);
      last = cyc;
      bus.req[idb] = 1'b0;
    end
    tick();
    tick();
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    // data_a nibbles 0..7 = 0..7, data_b nibbles 0..7 = 8..F
    vecs[0] = '{req: 4'b0010, id: 2'd1, sel_a: 12'b011_010_001_000, sel_b: 12'h000,
                sel_ab: 4'h0, exp_result: 16'h3210};
    vecs[1] = '{req: 4'b0100, id: 2'd2, sel_a: 12'h000, sel_b: 12'b000_001_010_011,
                sel_ab: 4'hF, exp_result: 16'h89AB};
    // lanes: n0 A[3]=3, n1 B[1]=9, n2 A[1]=1, n3 B[3]=B
    vecs[2] = '{req: 4'b0001, id: 2'd0, sel_a: 12'b000_001_010_011, sel_b: 12'b011_010_001_000,
                sel_ab: 4'b1010, exp_result: 16'hB193};
    vecs[3] = '{req: 4'b1000, id: 2'd3, sel_a: 12'b111_110_101_100, sel_b: 12'h000,
                sel_ab: 4'h0, exp_result: 16'h7654};
    vecs[4] = '{req: 4'b0010, id: 2'd1, sel_a: 12'h000, sel_b: 12'b111_111_000_000,
                sel_ab: 4'b1100, exp_result: 16'hFF00};

    reset          = 1'b1;
    bus.req        = '0;
    bus.req_sel_a  = '0;
    bus.req_sel_b  = '0;
    bus.req_sel_ab = '0;
    tick();
    tick();
    chk("rst_gnt",    32'(bus.gnt), 32'd0);
    chk("rst_busy",   32'(bus.busy), 32'd0);
    chk("rst_done",   32'(bus.done), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_sel_a",  32'(sel_a), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while in WAIT: no done, everything cleared, pointer back to 0
    bus.req = 4'b0100;
    tick();  // edge 0
    bus.req = '0;
    tick();  // edge 1, now in WAIT
    reset = 1'b1;
    tick();
    chk("mid_done",    32'(bus.done), 32'd0);
    chk("mid_busy",    32'(bus.busy), 32'd0);
    chk("mid_gnt",     32'(bus.gnt), 32'd0);
    chk("mid_sel_b",   32'(sel_b), 32'd0);
    chk("mid_sel_ab",  32'(sel_ab), 32'd0);
    chk("mid_result",  32'(bus.result), 32'd0);
    chk("mid_done_id", 32'(bus.done_id), 32'd0);
    $display("txn mid_reset busy=%0d done=%0d", bus.busy, bus.done);
    reset = 1'b0;
    tick();
    chk("mid_no_done", 32'(bus.done), 32'd0);

    // Pointer is 0 after reset: order 0,1,2,3 in both builds
    rr_run(8'b11_10_01_00, "rr");

    // A lone grant to 2 leaves the pointer at 3, then all four again
    run_vec(vecs[1], "pre_wrap");
`ifdef SELECTOR_ARB_FIXED_PRIO_EN
    rr_run(8'b11_10_01_00, "wrap");
`else
    rr_run(8'b10_01_00_11, "wrap");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
